// File: rtl/matvec_pkg.sv
// Shared types, defaults and helpers for the matrix-vector engine and its MAC lanes.
// Pure declarations: no logic, no latency, no flow control.
package matvec_pkg;
  localparam int DW_DEF    = 8;
  localparam int NMAX_DEF  = 8;
  localparam int LANES_DEF = 2;
  localparam int NW_DEF    = $clog2(NMAX_DEF + 1);
  localparam int RW_DEF    = 2 * DW_DEF + $clog2(NMAX_DEF);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMPUTE, ST_DRAIN} mv_state_e;

  typedef logic [DW_DEF-1:0] operand_t;
  typedef logic [NW_DEF-1:0] size_t;
  typedef logic [RW_DEF-1:0] result_t;

  function automatic logic size_ok(input int unsigned sz, input int unsigned nmax);
    return (sz != 0) && (sz <= nmax);
  endfunction
endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One unsigned multiply-accumulate lane; acc updates one cycle after en, masked lanes hold.
// No backpressure: the controller sequences clr/en directly.
module mac_lane
  import matvec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          mask,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [RW-1:0] acc
);
  logic [2*DW-1:0] prod;
  logic [RW-1:0]   acc_d, acc_q;

  assign prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en && !mask) begin
      acc_d = acc_q + {{(RW-2*DW){1'b0}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
endmodule

// File: rtl/matvec_engine.sv
// y = A*x engine: byte-serial load, LANES parallel MACs, result FIFO drained via valid/pop.
// Last push to done = 1 + sum over row groups of (n + lanes in group) cycles; pushes outside IDLE/LOAD are dropped.
module matvec_engine
  import matvec_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int NMAX  = NMAX_DEF,
  parameter  int LANES = LANES_DEF,
  localparam int NW    = $clog2(NMAX + 1),
  localparam int RW    = 2 * DW + $clog2(NMAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] data_in,
  input  logic          push_A,
  input  logic          push_B,
  input  logic          clear,
  input  logic          pop,
  output logic          full_A,
  output logic          empty_A,
  output logic          full_B,
  output logic          busy,
  output logic          size_err,
  output logic          valid,
  output logic [RW-1:0] result,
  output logic          done
);
  localparam int AW  = $clog2(NMAX * NMAX);
  localparam int CAW = $clog2(NMAX * NMAX + 1);
  localparam int BW  = $clog2(NMAX);
  localparam int PW  = 2 * NW;

  mv_state_e      state_d, state_q;
  logic [NW-1:0]  n_d, n_q;
  logic           size_err_d, size_err_q;
  logic [CAW-1:0] cnt_a_d, cnt_a_q;
  logic [NW-1:0]  cnt_b_d, cnt_b_q;
  logic           full_a_d, full_a_q;
  logic           full_b_d, full_b_q;
  logic [NW-1:0]  row_base_d, row_base_q;
  logic [NW-1:0]  j_d, j_q;
  logic [NW-1:0]  k_d, k_q;
  logic           wr_ph_d, wr_ph_q;
  logic           done_d, done_q;
  logic [BW-1:0]  wr_ptr_d, wr_ptr_q;
  logic [BW-1:0]  rd_ptr_d, rd_ptr_q;
  logic [NW-1:0]  f_cnt_d, f_cnt_q;
  logic [RW-1:0]  result_d, result_q;

  logic             wr_a, wr_b, fifo_wr, fifo_pop, lane_en, lane_clr;
  logic [PW-1:0]    nn_d;
  logic [RW-1:0]    wdata;
  logic [LANES-1:0] lane_mask;
  logic [RW-1:0]    acc_w [LANES];

  logic [DW-1:0] mem_a    [NMAX*NMAX];
  logic [DW-1:0] mem_b    [NMAX];
  logic [RW-1:0] fifo_mem [NMAX];

  function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
    return (p == BW'(NMAX - 1)) ? '0 : p + BW'(1);
  endfunction

  // Lane gi of the current group owns row row_base_q+gi; rows past n_q are masked.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [NW-1:0] row;
    logic [AW-1:0] addr;
    assign row          = row_base_q + NW'(gi);
    assign addr         = AW'(row) * AW'(n_q) + AW'(j_q);
    assign lane_mask[gi] = (row >= n_q);

    mac_lane #(.DW(DW), .RW(RW)) u_mac (
      .clk  (clk),
      .rst  (rst || clear),
      .clr  (lane_clr),
      .en   (lane_en),
      .mask (lane_mask[gi]),
      .a_in (mem_a[addr]),
      .b_in (mem_b[BW'(j_q)]),
      .acc  (acc_w[gi])
    );
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (k_q == NW'(i)) wdata = acc_w[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    size_err_d = size_err_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    full_a_d   = full_a_q;
    full_b_d   = full_b_q;
    row_base_d = row_base_q;
    j_d        = j_q;
    k_d        = k_q;
    wr_ph_d    = wr_ph_q;
    done_d     = 1'b0;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    fifo_wr    = 1'b0;
    lane_en    = 1'b0;
    lane_clr   = (state_q != ST_COMPUTE);

    case (state_q)
      ST_IDLE: begin
        if (push_A || push_B) begin
          n_d = n;
          if (!size_ok(32'(n), NMAX)) begin
            size_err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            wr_a    = push_A;
            wr_b    = push_B;
          end
        end
      end
      ST_LOAD: begin
        wr_a = push_A && !full_a_q;
        wr_b = push_B && !full_b_q;
        if (full_a_q && full_b_q) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (!wr_ph_q) begin
          lane_en = 1'b1;
          if (j_q == n_q - NW'(1)) begin
            j_d     = '0;
            wr_ph_d = 1'b1;
          end else begin
            j_d = j_q + NW'(1);
          end
        end else begin
          fifo_wr = 1'b1;
          if (row_base_q + k_q + NW'(1) == n_q) begin
            done_d     = 1'b1;
            state_d    = ST_DRAIN;
            wr_ph_d    = 1'b0;
            k_d        = '0;
            row_base_d = '0;
            lane_clr   = 1'b1;
          end else if (k_q == NW'(LANES - 1)) begin
            row_base_d = row_base_q + NW'(LANES);
            k_d        = '0;
            wr_ph_d    = 1'b0;
            lane_clr   = 1'b1;
          end else begin
            k_d = k_q + NW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if ((f_cnt_q == '0) || ((f_cnt_q == NW'(1)) && pop)) begin
          state_d  = ST_IDLE;
          cnt_a_d  = '0;
          cnt_b_d  = '0;
          full_a_d = 1'b0;
          full_b_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fullness is judged against the size latched this cycle, so a first push in IDLE counts too.
    nn_d = PW'(n_d) * PW'(n_d);
    if (wr_a) begin
      cnt_a_d  = cnt_a_q + CAW'(1);
      full_a_d = (PW'(cnt_a_q) + PW'(1) == nn_d);
    end
    if (wr_b) begin
      cnt_b_d  = cnt_b_q + NW'(1);
      full_b_d = (cnt_b_q + NW'(1) == n_d);
    end
  end

  // Result FIFO; result_q always mirrors the head that will be visible after this edge.
  always_comb begin
    fifo_pop = pop && (f_cnt_q != '0);
    wr_ptr_d = fifo_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    f_cnt_d  = f_cnt_q;
    if (fifo_wr && !fifo_pop) begin
      f_cnt_d = f_cnt_q + NW'(1);
    end else if (!fifo_wr && fifo_pop) begin
      f_cnt_d = f_cnt_q - NW'(1);
    end
    if (f_cnt_d == '0) begin
      result_d = '0;
    end else if ((f_cnt_q == '0) || (fifo_pop && (f_cnt_q == NW'(1)))) begin
      result_d = wdata;
    end else begin
      result_d = fifo_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      size_err_q <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      full_a_q   <= 1'b0;
      full_b_q   <= 1'b0;
      row_base_q <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wr_ph_q    <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      f_cnt_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      size_err_q <= size_err_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      full_a_q   <= full_a_d;
      full_b_q   <= full_b_d;
      row_base_q <= row_base_d;
      j_q        <= j_d;
      k_q        <= k_d;
      wr_ph_q    <= wr_ph_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      f_cnt_q    <= f_cnt_d;
      result_q   <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a)    mem_a[AW'(cnt_a_q)] <= data_in;
    if (wr_b)    mem_b[BW'(cnt_b_q)] <= data_in;
    if (fifo_wr) fifo_mem[wr_ptr_q]  <= wdata;
  end

  assign full_A   = full_a_q;
  assign empty_A  = (cnt_a_q == '0);
  assign full_B   = full_b_q;
  assign busy     = (state_q == ST_COMPUTE);
  assign size_err = size_err_q;
  assign valid    = (f_cnt_q != '0);
  assign result   = result_q;
  assign done     = done_q;
endmodule
